id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the 5-stage pipeline; sits directly downstream of the register file.
- Captures register-file read data plus decoded fields into the EX pipeline register.
- Bypasses same-cycle writeback data, because the register file writes on posedge and reads combinationally.
- Detects load-use hazards (raises stall_d, inserts a bubble) and squashes on branch/jump redirect.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous active-high reset
- d_valid  in  1  D stage holds a real instruction
- d_rs1, d_rs2, d_rd  in  REG_AW each  decoded register addresses
- d_rd_data1, d_rd_data2  in  XLEN each  register file read data
- d_imm  in  XLEN  extended immediate
- d_pc  in  XLEN  instruction PC
- d_ctrl  in  ctrl_t  decoded control bundle
- w_we  in  1  writeback register write enable
- w_rd  in  REG_AW  writeback destination
- w_result  in  XLEN  writeback data
- ex_flush  in  1  branch/jump taken in EX this cycle
- e_valid  out  1  EX stage holds a real instruction
- e_rs1, e_rs2, e_rd  out  REG_AW each  registered addresses (used by the forwarding unit)
- e_src1, e_src2  out  XLEN each  registered operands
- e_imm, e_pc  out  XLEN each  registered
- e_ctrl  out  ctrl_t  registered control
- stall_d  out  1  hold F and D this cycle
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (async, immediate):
  - e_valid=0; e_ctrl all-zero (no side effects).
  - e_rs*, e_rd, e_src*, e_imm, e_pc all 0.
  - stall_cnt=0; stall_d therefore 0.
- Operand bypass (combinational, before the register):
  - src1 = w_result if w_we and w_rd!=0 and w_rd==d_rs1; otherwise d_rd_data1.
  - src2 follows the same rule with d_rs2.
  - x0 is never bypassed.
- Load-use hazard (combinational from registered E state and current D inputs):
  - hz = e_valid & e_ctrl.mem_read & e_rd!=0 & d_valid & ((d_ctrl.uses_rs1 & d_rs1==e_rd) | (d_ctrl.uses_rs2 & d_rs2==e_rd)).
  - stall_d = hz & ~ex_flush.
- Register update each posedge, first matching rule wins:
  1. ex_flush: E becomes a bubble (e_valid=0, e_ctrl=0; other fields don't-care but zeroed).
  2. stall_d: E becomes a bubble. D is held by upstream and re-read next cycle; the bypass covers a WB write landing in the stall cycle.
  3. Otherwise: capture all D fields; e_valid=d_valid. If d_valid=0, e_ctrl is forced to 0.
- Latency: 1 cycle D→E. Exactly one bubble per load-use pair, because the load leaves E the next cycle.
- stall_cnt:
  - Increments on every cycle with stall_d=1.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared only by reset.
- Simultaneous events:
  - ex_flush with hz: flush wins, no stall. The D instruction is wrong-path and is flushed upstream.
  - Bypass and hazard together: bypass still applied; the captured value is irrelevant because a bubble is inserted.
- Reset mid-stall: stall_d drops immediately, since e_valid=0.

Decomposition:
- Package riscv_pkg holds:
  - ctrl_t packed struct: reg_write, mem_read, mem_write, alu_src, branch, jump, uses_rs1, uses_rs2, alu_op[3:0], result_src[1:0].
  - CTRL_NOP constant (all-zero).
  - XLEN and REG_AW constants.
- One sub-module, wb_bypass: a single-operand bypass mux, instantiated twice.
- Hazard logic and the register stay inline.

Test Plan:
- Reset asserted mid-run with e_valid=1 → all outputs 0 asynchronously, before the next clk edge; stall_cnt=0.
- D: add rd=x5, rs1=x1 (d_rd_data1=0x10), rs2=x2 (0x20) → next cycle e_valid=1, e_src1=0x10, e_src2=0x20, e_rd=5.
- Bypass: d_rs1=x3, d_rd_data1=0xAAAA, w_we=1, w_rd=3, w_result=0x1234 → e_src1=0x1234. Repeat with w_rd=0 and d_rs1=0 → no bypass; e_src1 equals d_rd_data1.
- Load-use: E holds lw rd=x7, D holds add with rs2=x7 and uses_rs2=1 → stall_d=1 one cycle; E bubble (e_valid=0, e_ctrl=0); next cycle the add is captured; stall_cnt=1. Same case with uses_rs2=0 → no stall.
- Flush precedence: load-use hazard present and ex_flush=1 → stall_d=0, E bubble, stall_cnt unchanged.
- Saturation: CNT_W=4, force 20 consecutive hazard cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline types: decoded control bundle and datapath widths.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       uses_rs1;
    logic       uses_rs2;
    logic [3:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/wb_bypass.sv
// Single-operand writeback bypass mux; purely combinational, no backpressure.
// Covers the register file's write-on-edge / read-combinational gap; x0 is never bypassed.
module wb_bypass #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              w_we,
  input  logic [REG_AW-1:0] w_rd,
  input  logic [XLEN-1:0]   w_result,
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rd_data,
  output logic [XLEN-1:0]   src
);

  always_comb begin
    src = rd_data;
    if (w_we && (w_rd != '0) && (w_rd == rs)) begin
      src = w_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// D->E pipeline register with WB bypass, load-use stall and redirect squash; 1-cycle latency.
// Backpressure: raises stall_d (upstream holds F/D) and inserts one bubble per load-use pair.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic [XLEN-1:0]   d_rd_data1,
  input  logic [XLEN-1:0]   d_rd_data2,
  input  logic [XLEN-1:0]   d_imm,
  input  logic [XLEN-1:0]   d_pc,
  input  ctrl_t             d_ctrl,
  input  logic              w_we,
  input  logic [REG_AW-1:0] w_rd,
  input  logic [XLEN-1:0]   w_result,
  input  logic              ex_flush,
  output logic              e_valid,
  output logic [REG_AW-1:0] e_rs1,
  output logic [REG_AW-1:0] e_rs2,
  output logic [REG_AW-1:0] e_rd,
  output logic [XLEN-1:0]   e_src1,
  output logic [XLEN-1:0]   e_src2,
  output logic [XLEN-1:0]   e_imm,
  output logic [XLEN-1:0]   e_pc,
  output ctrl_t             e_ctrl,
  output logic              stall_d,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              e_valid_q, e_valid_d;
  logic [REG_AW-1:0] e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d, e_rd_q, e_rd_d;
  logic [XLEN-1:0]   e_src1_q, e_src1_d, e_src2_q, e_src2_d;
  logic [XLEN-1:0]   e_imm_q, e_imm_d, e_pc_q, e_pc_d;
  ctrl_t             e_ctrl_q, e_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]   src1, src2;
  logic              hz;

  wb_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_byp1 (
    .w_we(w_we), .w_rd(w_rd), .w_result(w_result),
    .rs(d_rs1), .rd_data(d_rd_data1), .src(src1)
  );

  wb_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_byp2 (
    .w_we(w_we), .w_rd(w_rd), .w_result(w_result),
    .rs(d_rs2), .rd_data(d_rd_data2), .src(src2)
  );

  // A load in E cannot forward in time to a dependent instruction in D.
  assign hz = e_valid_q && e_ctrl_q.mem_read && (e_rd_q != '0) && d_valid &&
              ((d_ctrl.uses_rs1 && (d_rs1 == e_rd_q)) ||
               (d_ctrl.uses_rs2 && (d_rs2 == e_rd_q)));
  assign stall_d = hz && !ex_flush;

  always_comb begin
    e_valid_d   = 1'b0;
    e_rs1_d     = '0;
    e_rs2_d     = '0;
    e_rd_d      = '0;
    e_src1_d    = '0;
    e_src2_d    = '0;
    e_imm_d     = '0;
    e_pc_d      = '0;
    e_ctrl_d    = CTRL_NOP;
    stall_cnt_d = stall_cnt_q;
    if (!ex_flush && !stall_d) begin
      e_valid_d = d_valid;
      e_rs1_d   = d_rs1;
      e_rs2_d   = d_rs2;
      e_rd_d    = d_rd;
      e_src1_d  = src1;
      e_src2_d  = src2;
      e_imm_d   = d_imm;
      e_pc_d    = d_pc;
      e_ctrl_d  = d_valid ? d_ctrl : CTRL_NOP;
    end
    if (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q   <= 1'b0;
      e_rs1_q     <= '0;
      e_rs2_q     <= '0;
      e_rd_q      <= '0;
      e_src1_q    <= '0;
      e_src2_q    <= '0;
      e_imm_q     <= '0;
      e_pc_q      <= '0;
      e_ctrl_q    <= CTRL_NOP;
      stall_cnt_q <= '0;
    end else begin
      e_valid_q   <= e_valid_d;
      e_rs1_q     <= e_rs1_d;
      e_rs2_q     <= e_rs2_d;
      e_rd_q      <= e_rd_d;
      e_src1_q    <= e_src1_d;
      e_src2_q    <= e_src2_d;
      e_imm_q     <= e_imm_d;
      e_pc_q      <= e_pc_d;
      e_ctrl_q    <= e_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign e_valid   = e_valid_q;
  assign e_rs1     = e_rs1_q;
  assign e_rs2     = e_rs2_q;
  assign e_rd      = e_rd_q;
  assign e_src1    = e_src1_q;
  assign e_src2    = e_src2_q;
  assign e_imm     = e_imm_q;
  assign e_pc      = e_pc_q;
  assign e_ctrl    = e_ctrl_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected E state is queued at drive time and checked after the edge.
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int CW = 4;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] s1, s2, imm, pc;
    ctrl_t       c;
  } e_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_rd_data1, d_rd_data2, d_imm, d_pc;
  ctrl_t       d_ctrl;
  logic        w_we;
  logic [4:0]  w_rd;
  logic [31:0] w_result;
  logic        ex_flush;
  logic        e_valid;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [31:0] e_src1, e_src2, e_imm, e_pc;
  ctrl_t       e_ctrl;
  logic        stall_d;
  logic [CW-1:0] stall_cnt;

  int n_chk = 0;
  int n_pass = 0;
  e_t exp_q[$];
  e_t model_e;
  int exp_cnt = 0;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_rd_data1(d_rd_data1), .d_rd_data2(d_rd_data2),
    .d_imm(d_imm), .d_pc(d_pc), .d_ctrl(d_ctrl),
    .w_we(w_we), .w_rd(w_rd), .w_result(w_result),
    .ex_flush(ex_flush), .e_valid(e_valid),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_src1(e_src1), .e_src2(e_src2), .e_imm(e_imm), .e_pc(e_pc),
    .e_ctrl(e_ctrl), .stall_d(stall_d), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic ctrl_t mk_ctrl(input bit ld, input bit u1, input bit u2);
    ctrl_t c;
    c = CTRL_NOP;
    c.reg_write  = 1'b1;
    c.mem_read   = ld;
    c.alu_src    = ld;
    c.uses_rs1   = u1;
    c.uses_rs2   = u2;
    c.result_src = ld ? 2'd1 : 2'd0;
    c.alu_op     = ld ? 4'd0 : 4'd2;
    return c;
  endfunction

  function automatic logic [31:0] byp(input logic [4:0] rs, input logic [31:0] data);
    if (w_we && w_rd != 5'd0 && w_rd == rs) return w_result;
    return data;
  endfunction

  function automatic e_t bubble();
    e_t b;
    b.v = 1'b0; b.rs1 = '0; b.rs2 = '0; b.rd = '0;
    b.s1 = '0; b.s2 = '0; b.imm = '0; b.pc = '0; b.c = CTRL_NOP;
    return b;
  endfunction

  task automatic drive_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input ctrl_t c);
    d_valid = v; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
    d_rd_data1 = a; d_rd_data2 = b; d_ctrl = c;
    d_imm = {27'd0, rd} ^ 32'h0000_0F00;
    d_pc  = d_pc + 32'd4;
  endtask

  // One clock: check stall_d before the edge, queue the expected E state, compare after the edge.
  task automatic cyc(input string tag);
    bit hz, stl;
    e_t nx, got;
    #1;
    hz = model_e.v && model_e.c.mem_read && model_e.rd != 5'd0 && d_valid &&
         ((d_ctrl.uses_rs1 && d_rs1 == model_e.rd) || (d_ctrl.uses_rs2 && d_rs2 == model_e.rd));
    stl = hz && !ex_flush;
    chk({tag, ".stall_d"}, stall_d, stl);
    if (ex_flush || stl) nx = bubble();
    else begin
      nx.v = d_valid; nx.rs1 = d_rs1; nx.rs2 = d_rs2; nx.rd = d_rd;
      nx.s1 = byp(d_rs1, d_rd_data1); nx.s2 = byp(d_rs2, d_rd_data2);
      nx.imm = d_imm; nx.pc = d_pc; nx.c = d_valid ? d_ctrl : CTRL_NOP;
    end
    if (stl && exp_cnt < (1 << CW) - 1) exp_cnt++;
    exp_q.push_back(nx);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({tag, ".e_valid"}, e_valid, got.v);
    chk({tag, ".e_ctrl"}, e_ctrl, got.c);
    chk({tag, ".e_src1"}, e_src1, got.s1);
    chk({tag, ".e_src2"}, e_src2, got.s2);
    chk({tag, ".e_fields"}, {e_rs1, e_rs2, e_rd, e_imm, e_pc}, {got.rs1, got.rs2, got.rd, got.imm, got.pc});
    chk({tag, ".stall_cnt"}, stall_cnt, exp_cnt[CW-1:0]);
    model_e = got;
  endtask

  initial begin
    reset = 1'b1; ex_flush = 1'b0; w_we = 1'b0; w_rd = '0; w_result = '0;
    d_pc = 32'h1000;
    drive_d(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, CTRL_NOP);
    model_e = bubble();
    #12;
    chk("rst.e_valid", e_valid, 1'b0);
    chk("rst.all", {e_rs1, e_rs2, e_rd, e_src1, e_src2, e_imm, e_pc, e_ctrl, stall_cnt}, 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    drive_d(1'b1, 5'd1, 5'd2, 5'd5, 32'h10, 32'h20, mk_ctrl(0, 1, 1));
    cyc("add");
    chk("add.valid_c", e_valid, 1'b1);
    chk("add.src_c", {e_src1, e_src2, 27'd0, e_rd}, {32'h10, 32'h20, 32'd5});

    w_we = 1'b1; w_rd = 5'd3; w_result = 32'h1234;
    drive_d(1'b1, 5'd3, 5'd4, 5'd6, 32'hAAAA, 32'h55, mk_ctrl(0, 1, 1));
    cyc("byp");
    chk("byp.src1_c", e_src1, 32'h1234);
    w_rd = 5'd0;
    drive_d(1'b1, 5'd0, 5'd4, 5'd6, 32'hAAAA, 32'h55, mk_ctrl(0, 1, 1));
    cyc("byp_x0");
    chk("byp_x0.src1_c", e_src1, 32'hAAAA);
    w_we = 1'b0;

    drive_d(1'b1, 5'd1, 5'd0, 5'd7, 32'h40, 32'h0, mk_ctrl(1, 1, 0));
    cyc("lw");
    drive_d(1'b1, 5'd2, 5'd7, 5'd8, 32'h1, 32'h2, mk_ctrl(0, 1, 1));
    #1;
    chk("lu.stall_c", stall_d, 1'b1);
    w_we = 1'b1; w_rd = 5'd7; w_result = 32'hBEEF;
    cyc("lu_stall");
    chk("lu.bubble_c", {e_valid, e_ctrl}, 15'd0);
    chk("lu.cnt_c", stall_cnt, 4'd1);
    cyc("lu_go");
    chk("lu.go_c", {e_valid, e_src2}, {1'b1, 32'hBEEF});
    w_we = 1'b0;

    drive_d(1'b1, 5'd1, 5'd0, 5'd7, 32'h40, 32'h0, mk_ctrl(1, 1, 0));
    cyc("lw2");
    drive_d(1'b1, 5'd2, 5'd7, 5'd8, 32'h1, 32'h2, mk_ctrl(0, 1, 0));
    cyc("nouse");
    chk("nouse.valid_c", e_valid, 1'b1);

    drive_d(1'b1, 5'd1, 5'd0, 5'd7, 32'h40, 32'h0, mk_ctrl(1, 1, 0));
    cyc("lw3");
    drive_d(1'b1, 5'd7, 5'd2, 5'd8, 32'h1, 32'h2, mk_ctrl(0, 1, 1));
    ex_flush = 1'b1;
    cyc("flush");
    chk("flush.c", {stall_cnt, e_valid}, {4'd1, 1'b0});
    ex_flush = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive_d(1'b1, 5'd1, 5'd0, 5'd9, 32'h40, 32'h0, mk_ctrl(1, 1, 0));
      cyc("sat_lw");
      drive_d(1'b1, 5'd9, 5'd3, 5'd10, 32'h1, 32'h2, mk_ctrl(0, 1, 1));
      cyc("sat_use");
    end
    chk("sat.cnt_c", stall_cnt, 4'd15);

    drive_d(1'b1, 5'd1, 5'd0, 5'd9, 32'h40, 32'h0, mk_ctrl(1, 1, 0));
    cyc("rlw");
    drive_d(1'b1, 5'd9, 5'd3, 5'd10, 32'h1, 32'h2, mk_ctrl(0, 1, 1));
    #2;
    chk("rst_mid.pre", {e_valid, stall_d}, 2'b11);
    reset = 1'b1;
    #1;
    chk("rst_mid.stall", stall_d, 1'b0);
    chk("rst_mid.all", {e_valid, e_rs1, e_rs2, e_rd, e_src1, e_src2, e_imm, e_pc, e_ctrl, stall_cnt}, 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_e = bubble();
    exp_cnt = 0;
    cyc("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
